mult_share_arbiter: RTL and testbench

- Round-robin arbiter that shares one sequential_multiplier instance between N_REQ requesters.
- Each requester hands over an operand pair with a valid/ready handshake and gets its product back on a per-requester response handshake.
- Sequences the multiplier's start/done protocol and recovers from a hung multiplier with a timeout.
- Sits between the client blocks and the single multiplier datapath.

---
 rtl/mult_share_arbiter.sv | 139 +++++++++++++
 tb/tb_mult_share_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_share_arbiter.sv
// rtl/mult_share_arbiter.sv - round-robin arbiter sharing one sequential multiplier
// between N_REQ requesters, with start/done sequencing and a WAIT timeout.
module mult_share_arbiter #(
  parameter int N_REQ   = 4,
  parameter int W       = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ*W-1:0]         req_a,
  input  logic [N_REQ*W-1:0]         req_b,
  output logic [N_REQ-1:0]           rsp_valid,
  input  logic [N_REQ-1:0]           rsp_ready,
  output logic [2*W-1:0]             rsp_product,
  output logic                       rsp_err,
  output logic                       busy,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       mult_start,
  output logic [W-1:0]               mult_a,
  output logic [W-1:0]               mult_b,
  input  logic [2*W-1:0]             mult_product,
  input  logic                       mult_done
);

  localparam int IW = $clog2(N_REQ);
  localparam int EW = IW + 1;
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [EW-1:0] N_EXT    = EW'(N_REQ);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t          state, next_state;
  logic [IW-1:0]   rr_ptr;
  logic [CW-1:0]   tmo_cnt;
  logic            timeout_hit;
  logic            win_found;
  logic [IW-1:0]   win_id;
  logic [EW-1:0]   cand;
  logic [W-1:0]    a_arr [N_REQ];
  logic [W-1:0]    b_arr [N_REQ];

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      a_arr[i] = req_a[i*W +: W];
      b_arr[i] = req_b[i*W +: W];
    end
  end

  // Search upward from rr_ptr+1 with wrap; the widened index avoids overflow on wrap.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = {1'b0, rr_ptr} + EW'(k);
      if (cand >= N_EXT) cand = cand - N_EXT;
      if (!win_found && req_valid[cand[IW-1:0]]) begin
        win_found = 1'b1;
        win_id    = cand[IW-1:0];
      end
    end
  end

  assign timeout_hit = (tmo_cnt == CNT_LAST);
  assign busy        = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    req_ready  = '0;
    case (state)
      S_IDLE: begin
        if (win_found) begin
          req_ready[win_id] = 1'b1;
          next_state        = S_ISSUE;
        end
      end
      S_ISSUE: next_state = S_WAIT;
      S_WAIT:  if (mult_done || timeout_hit) next_state = S_RESP;
      S_RESP:  if (rsp_ready[grant_id]) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rr_ptr      <= IW'(N_REQ - 1);
      grant_id    <= '0;
      mult_start  <= 1'b0;
      mult_a      <= '0;
      mult_b      <= '0;
      rsp_valid   <= '0;
      rsp_product <= '0;
      rsp_err     <= 1'b0;
      tmo_cnt     <= '0;
    end else begin
      mult_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (win_found) begin
            grant_id   <= win_id;
            mult_a     <= a_arr[win_id];
            mult_b     <= b_arr[win_id];
            mult_start <= 1'b1;
          end
        end
        S_ISSUE: tmo_cnt <= '0;
        S_WAIT: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          // A done arriving on the timeout cycle still delivers a good product.
          if (mult_done) begin
            rsp_product         <= mult_product;
            rsp_err             <= 1'b0;
            rsp_valid[grant_id] <= 1'b1;
          end else if (timeout_hit) begin
            rsp_product         <= '0;
            rsp_err             <= 1'b1;
            rsp_valid[grant_id] <= 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready[grant_id]) begin
            rsp_valid <= '0;
            rr_ptr    <= grant_id;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb/tb_mult_share_arbiter.sv - randomized self-checking bench for mult_share_arbiter
// against a transaction-level round-robin reference model.
module tb_mult_share_arbiter;

  localparam int N   = 4;
  localparam int W   = 8;
  localparam int TMO = 64;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [N-1:0]     req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N*W-1:0]   req_a, req_b;
  logic [2*W-1:0]   rsp_product, mult_product;
  logic             rsp_err, busy, mult_start, mult_done;
  logic [1:0]       grant_id;
  logic [W-1:0]     mult_a, mult_b;

  int n_tests = 0;
  int n_fail  = 0;

  int         last_grant, txn_cyc, owner, acc, bp_left, bp_next, max_wait;
  bit         in_txn, hs, bp_rand, dly_rand;
  int         dly_fixed, cur_delay, inject_cnt;
  logic [W-1:0] op_a [N];
  logic [W-1:0] op_b [N];
  logic [W-1:0] cur_a, cur_b;
  int         refill [N];
  int         waits [N];
  int         grant_log[$];
  int         prod_log[$];
  int         err_log[$];

  always #5 clk = ~clk;

  mult_share_arbiter #(.N_REQ(N), .W(W), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_product(rsp_product),
    .rsp_err(rsp_err), .busy(busy), .grant_id(grant_id),
    .mult_start(mult_start), .mult_a(mult_a), .mult_b(mult_b),
    .mult_product(mult_product), .mult_done(mult_done)
  );

  // Multiplier model: done pulse cur_delay cycles after start (0 = never).
  initial begin
    int cnt;
    int seen;
    cnt = 0; seen = 0; cur_delay = 0;
    mult_done = 1'b0; mult_product = '0;
    forever begin
      @(negedge clk);
      mult_done    = 1'b0;
      mult_product = 16'($urandom);
      if (!reset_n) cnt = 0;
      else begin
        if (inject_cnt != seen) begin
          seen = inject_cnt;
          mult_done = 1'b1;
        end
        if (mult_start) begin
          cur_delay = dly_rand ? $urandom_range(1, 20) : dly_fixed;
          cnt = cur_delay;
        end else if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            mult_done    = 1'b1;
            mult_product = 16'(mult_a) * 16'(mult_b);
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int qget(input int q[$], input int idx);
    if (idx < 0 || idx >= q.size()) return -1;
    return q[idx];
  endfunction

  function automatic int rr_pick();
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (last_grant + k) % N;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    op_a[i] = a;
    op_b[i] = b;
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  task automatic request(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input int rf);
    set_ops(i, a, b);
    refill[i]    = rf;
    req_valid[i] = 1'b1;
  endtask

  task automatic reset_model();
    in_txn = 0; txn_cyc = 0; acc = -1; hs = 0; bp_left = 0; max_wait = 0;
    last_grant = N - 1;
    for (int i = 0; i < N; i++) begin refill[i] = 0; waits[i] = 0; end
    grant_log.delete(); prod_log.delete(); err_log.delete();
  endtask

  task automatic check_zero();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_product", rsp_product, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_mult_start", mult_start, 0);
    chk("rst_mult_a", mult_a, 0);
    chk("rst_mult_b", mult_b, 0);
  endtask

  task automatic apply_reset();
    reset_n = 1'b0; req_valid = '0; rsp_ready = '0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    reset_model();
    @(negedge clk);
    check_zero();
    @(posedge clk); #1;
  endtask

  // One clock: check outputs at negedge against the model, then commit the edge.
  task automatic step();
    logic [N-1:0]   exp_ready, onehot;
    logic [2*W-1:0] tprod;
    int w, rsp_cyc;
    bit rv, terr;
    @(negedge clk);
    exp_ready = '0; w = -1; onehot = '0; rv = 0; terr = 0;
    if (!in_txn) begin
      w = rr_pick();
      if (w >= 0) exp_ready[w] = 1'b1;
    end
    chk("req_ready", req_ready, exp_ready);
    chk("busy", busy, in_txn);
    chk("mult_start", mult_start, in_txn && txn_cyc == 1);
    if (in_txn) begin
      onehot[owner] = 1'b1;
      chk("grant_id", grant_id, owner);
      chk("mult_a", mult_a, cur_a);
      chk("mult_b", mult_b, cur_b);
      if (txn_cyc >= 2) begin
        terr    = !(cur_delay >= 1 && cur_delay <= TMO);
        rsp_cyc = terr ? TMO + 2 : cur_delay + 2;
        rv      = (txn_cyc >= rsp_cyc);
      end
    end
    chk("rsp_valid", rsp_valid, rv ? onehot : '0);
    rsp_ready = 4'($urandom);
    if (rv) begin
      tprod = terr ? '0 : 16'(cur_a) * 16'(cur_b);
      chk("rsp_product", rsp_product, tprod);
      chk("rsp_err", rsp_err, terr);
      if (bp_left > 0) begin
        bp_left--;
        rsp_ready = 4'($urandom) & ~onehot;
      end else begin
        rsp_ready = 4'($urandom) | onehot;
        hs = 1;
        prod_log.push_back(int'(tprod));
        err_log.push_back(int'(terr));
      end
    end
    if (w >= 0) begin
      acc = w; owner = w; cur_a = op_a[w]; cur_b = op_b[w]; last_grant = w;
      grant_log.push_back(w);
      for (int i = 0; i < N; i++) begin
        if (i != w && req_valid[i]) begin
          waits[i]++;
          if (waits[i] > max_wait) max_wait = waits[i];
        end
      end
      waits[w] = 0;
      bp_left = bp_rand ? $urandom_range(0, 3) : bp_next;
      bp_next = 0;
    end
    @(posedge clk); #1;
    if (acc >= 0) begin
      in_txn = 1; txn_cyc = 1;
      if (refill[acc] > 0) begin
        refill[acc]--;
        set_ops(acc, 8'($urandom), 8'($urandom));
      end else req_valid[acc] = 1'b0;
      acc = -1;
    end else if (in_txn) txn_cyc++;
    if (hs) begin in_txn = 0; hs = 0; end
  endtask

  task automatic drain(input int maxc);
    int c;
    c = 0;
    while ((in_txn || req_valid != 0) && c < maxc) begin step(); c++; end
    chk("drain_done", {in_txn, (req_valid != 0)}, 0);
  endtask

  initial begin
    int g;
    reset_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = '0;
    dly_fixed = 9; dly_rand = 0; bp_rand = 0; bp_next = 0; inject_cnt = 0;
    cur_a = '0; cur_b = '0; owner = 0;
    apply_reset();

    // single request
    request(1, 13, 11, 0);
    drain(200);
    chk("single_grant", qget(grant_log, 0), 1);
    chk("single_product", qget(prod_log, 0), 143);
    chk("single_err", qget(err_log, 0), 0);

    // all four from reset
    apply_reset();
    dly_rand = 1;
    request(0, 3, 5, 0); request(1, 7, 9, 0); request(2, 255, 255, 0); request(3, 0, 200, 0);
    drain(400);
    for (int i = 0; i < N; i++) chk("four_grant_order", qget(grant_log, i), i);
    chk("four_p0", qget(prod_log, 0), 15);
    chk("four_p1", qget(prod_log, 1), 63);
    chk("four_p2", qget(prod_log, 2), 65025);
    chk("four_p3", qget(prod_log, 3), 0);

    // fairness after a grant to 2
    apply_reset();
    request(2, 4, 4, 0);
    drain(200);
    request(0, 6, 7, 0); request(3, 8, 9, 0);
    drain(400);
    chk("fair_next3", qget(grant_log, 1), 3);
    chk("fair_then0", qget(grant_log, 2), 0);
    max_wait = 0;
    for (int i = 0; i < N; i++) begin waits[i] = 0; request(i, 8'($urandom), 8'($urandom), 5); end
    drain(2000);
    chk("fair_max_wait", max_wait, N - 1);

    // response backpressure with others pending
    bp_next = 10;
    request(1, 20, 30, 0); request(2, 11, 12, 0); request(3, 200, 2, 0);
    drain(500);
    chk("bp_count", grant_log.size(), 3 + 24 + 3);

    // timeouts
    dly_rand = 0;
    dly_fixed = 0;   request(0, 9, 9, 0);  drain(300);
    chk("tmo_err", qget(err_log, err_log.size() - 1), 1);
    chk("tmo_prod", qget(prod_log, prod_log.size() - 1), 0);
    dly_fixed = 3;   request(1, 12, 12, 0); drain(300);
    chk("after_tmo_err", qget(err_log, err_log.size() - 1), 0);
    chk("after_tmo_prod", qget(prod_log, prod_log.size() - 1), 144);
    dly_fixed = TMO; request(2, 100, 3, 0); drain(300);
    chk("coincide_err", qget(err_log, err_log.size() - 1), 0);
    chk("coincide_prod", qget(prod_log, prod_log.size() - 1), 300);
    dly_fixed = TMO + 1; request(3, 5, 5, 0); drain(300);
    chk("late_done_err", qget(err_log, err_log.size() - 1), 1);

    // reset during WAIT
    dly_fixed = 30;
    request(1, 13, 11, 0);
    g = 0;
    while (!(in_txn && txn_cyc == 5) && g < 50) begin step(); g++; end
    chk("reached_wait", (in_txn && txn_cyc == 5), 1);
    reset_n = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
    reset_model();
    @(negedge clk);
    check_zero();
    @(posedge clk); #1;
    inject_cnt++;
    repeat (4) step();
    request(2, 2, 3, 0); request(0, 4, 5, 0);
    drain(300);
    chk("post_rst_first", qget(grant_log, 0), 0);
    chk("post_rst_second", qget(grant_log, 1), 2);

    // randomized traffic
    dly_rand = 1; bp_rand = 1;
    repeat (600) begin
      for (int i = 0; i < N; i++)
        if (!req_valid[i] && $urandom_range(0, 7) == 0)
          request(i, 8'($urandom), 8'($urandom), $urandom_range(0, 2));
      step();
    end
    drain(3000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
